// File: rtl/sc_operand_fetch.sv
// sc_operand_fetch: latches two operands from fixed/general register buses and hands them to the ALU
module sc_operand_fetch #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int DATAWIDTH_SEL = 2,
    parameter int DATAWIDTH_CNT = 8
) (
    input  logic                     SC_RegFIXED_CLOCK_50,
    input  logic                     SC_RegFIXED_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] fixed0_in,
    input  logic [DATAWIDTH_BUS-1:0] fixed1_in,
    input  logic [DATAWIDTH_BUS-1:0] gen0_in,
    input  logic [DATAWIDTH_BUS-1:0] gen1_in,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATAWIDTH_SEL-1:0] req_selA,
    input  logic [DATAWIDTH_SEL-1:0] req_selB,
    output logic [DATAWIDTH_BUS-1:0] opA_out,
    output logic [DATAWIDTH_BUS-1:0] opB_out,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic                     busy,
    output logic [DATAWIDTH_CNT-1:0] xfer_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    logic [1:0]               state_q, state_d;
    logic [DATAWIDTH_SEL-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [DATAWIDTH_BUS-1:0] op_a_q, op_a_d, op_b_q, op_b_d, bus_a, bus_b;
    logic [DATAWIDTH_CNT-1:0] cnt_q, cnt_d;
    logic                     accept, done;
    always_comb begin
        bus_a = sel_a_q == DATAWIDTH_SEL'(0) ? fixed0_in :
                sel_a_q == DATAWIDTH_SEL'(1) ? fixed1_in :
                sel_a_q == DATAWIDTH_SEL'(2) ? gen0_in : gen1_in;
        bus_b = sel_b_q == DATAWIDTH_SEL'(0) ? fixed0_in :
                sel_b_q == DATAWIDTH_SEL'(1) ? fixed1_in :
                sel_b_q == DATAWIDTH_SEL'(2) ? gen0_in : gen1_in;
        accept  = (state_q == IDLE) && req_valid;
        done    = (state_q == HOLD) && op_ready;
        // the unused encoding falls back to IDLE
        state_d = accept ? CAPTURE :
                  state_q == CAPTURE ? HOLD :
                  (state_q == HOLD && !op_ready) ? HOLD : IDLE;
        sel_a_d = accept ? req_selA : sel_a_q;
        sel_b_d = accept ? req_selB : sel_b_q;
        op_a_d  = state_q == CAPTURE ? bus_a : op_a_q;
        op_b_d  = state_q == CAPTURE ? bus_b : op_b_q;
        cnt_d   = cnt_q + {{(DATAWIDTH_CNT-1){1'b0}}, done};
    end
    always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
        if (SC_RegFIXED_RESET_InHigh) begin
            state_q <= IDLE;
            sel_a_q <= '0;
            sel_b_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
        end
    end
    assign req_ready  = state_q == IDLE;
    assign op_valid   = state_q == HOLD;
    assign busy       = state_q != IDLE;
    assign opA_out    = op_a_q;
    assign opB_out    = op_b_q;
    assign xfer_count = cnt_q;
endmodule
